// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and backing-memory port
// around the unified memory arbiter.
// slave  : the arbiter's view (serves the CPU ports, drives the memory port)
// master : the surrounding system's view (CPU requesters plus memory model)
interface mem_arbiter_if;
    // instruction fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        i_err;
    // data access port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    // backing memory port
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_ready, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ready, d_rdata, d_err,
        output m_req, m_we, m_addr, m_wdata,
        input  m_ack, m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_ready, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ready, d_rdata, d_err,
        input  m_req, m_we, m_addr, m_wdata,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-ported
// memory. Data wins ties unless it has already won STREAK_MAX times in a
// row while a fetch waited. A request the memory never acknowledges is
// retired with an error after TIMEOUT busy cycles. All outputs registered.
module mem_arbiter #(
    parameter int STREAK_MAX = 4,   // 1..15
    parameter int TIMEOUT    = 255  // 1..255
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic       PORT_INST  = 1'b0;
    localparam logic       PORT_DATA  = 1'b1;

    state_t      state_q;
    logic        gnt_q;        // port that owns the memory
    logic [3:0]  streak_q;     // consecutive data grants with a fetch waiting
    logic [7:0]  tmo_q;        // busy cycles elapsed without an ack

    logic        m_req_q;
    logic        m_we_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic        i_ready_q, d_ready_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        i_err_q, d_err_q;

    logic        grant_any_d;
    logic        grant_data_d;
    logic [3:0]  streak_d;
    logic        finish_d;
    logic [31:0] rdata_d;
    logic        err_d;

    // Grant decision and completion result, consumed by the FSM below
    always_comb begin
        grant_any_d  = bus.i_req | bus.d_req;
        // data only loses when a fetch is waiting and the streak is spent
        grant_data_d = bus.d_req & ~(bus.i_req & (streak_q >= STREAK_LIM));
        streak_d     = 4'd0;
        if (grant_data_d && bus.i_req) begin
            streak_d = (streak_q >= STREAK_LIM) ? STREAK_LIM : streak_q + 4'd1;
        end
        // an ack in the last allowed cycle still counts as success
        finish_d = bus.m_ack | (tmo_q == TMO_LAST);
        err_d    = ~bus.m_ack;
        rdata_d  = (bus.m_ack && !m_we_q) ? bus.m_rdata : 32'd0;
    end

    // Arbiter FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= PORT_INST;
            streak_q  <= 4'd0;
            tmo_q     <= 8'd0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
        end else begin
            // ready is a single-cycle pulse
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any_d) begin
                        gnt_q    <= grant_data_d;
                        streak_q <= streak_d;
                        tmo_q    <= 8'd0;
                        m_req_q  <= 1'b1;
                        state_q  <= BUSY;
                        if (grant_data_d) begin
                            m_addr_q  <= bus.d_addr;
                            m_we_q    <= bus.d_we;
                            m_wdata_q <= bus.d_wdata;
                        end else begin
                            m_addr_q  <= bus.i_addr;
                            m_we_q    <= 1'b0;
                            m_wdata_q <= 32'd0;
                        end
                    end
                end
                BUSY: begin
                    if (finish_d) begin
                        m_req_q <= 1'b0;
                        state_q <= DONE;
                        if (gnt_q == PORT_DATA) begin
                            d_ready_q <= 1'b1;
                            d_rdata_q <= rdata_d;
                            d_err_q   <= err_d;
                        end else begin
                            i_ready_q <= 1'b1;
                            i_rdata_q <= rdata_d;
                            i_err_q   <= err_d;
                        end
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_ready = i_ready_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.i_err   = i_err_q;
    assign bus.d_ready = d_ready_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_err   = d_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single accesses, hand-written corner
// sequences, and a queue of expected completions popped on each ready.
module tb_mem_arbiter;
    localparam int STREAK_MAX = 4;
    localparam int TIMEOUT    = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STREAK_MAX(STREAK_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int lat_cfg = 1;          // ack in this BUSY cycle; 0 = never ack
    bit late_ack = 1'b0;      // force a stray ack in the next half cycle
    logic [31:0] mem_img [bit [31:0]];

    typedef struct {
        bit          port;    // 0 = instruction, 1 = data
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] mrd;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // Backing memory model: acks in BUSY cycle lat_cfg, driven mid-cycle
    initial begin
        int   cnt;
        logic ack;
        cnt = 0;
        bus.m_ack = 1'b0;
        bus.m_rdata = 32'd0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (bus.m_req) begin
                cnt++;
                if (lat_cfg != 0 && cnt == lat_cfg) ack = 1'b1;
            end else begin
                cnt = 0;
            end
            if (late_ack) ack = 1'b1;
            bus.m_ack = ack;
            bus.m_rdata = !ack ? 32'd0 : (bus.m_req ? rdata_of(bus.m_addr) : 32'hBAD0_BAD0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare a completion against the oldest scoreboard entry
    task automatic pop_cmp(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: ready seen with nothing expected", name);
            return;
        end
        e = exp_q.pop_front();
        chk({name, "_both"}, 32'(bus.i_ready & bus.d_ready), 32'd0);
        chk({name, "_port"}, 32'(bus.d_ready), 32'(e.port));
        chk({name, "_rdata"}, e.port ? bus.d_rdata : bus.i_rdata, e.rdata);
        chk({name, "_err"}, 32'(e.port ? bus.d_err : bus.i_err), 32'(e.err));
    endtask

    // One access: drive, check the grant, wait for ready, check timing/results
    task automatic do_txn(input string name, input bit port, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, input logic [31:0] exp_rdata,
                          input bit exp_err, input bit keep, input bit inject_late);
        logic [31:0] oth_rdata;
        logic        oth_err;
        int n, mreq_n, exp_cyc;
        bit seen;
        oth_rdata = port ? bus.i_rdata : bus.d_rdata;
        oth_err   = port ? bus.i_err : bus.d_err;
        exp_cyc   = (lat == 0) ? TIMEOUT + 1 : lat + 1;
        lat_cfg   = lat;
        if (port) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        exp_q.push_back('{port, exp_rdata, exp_err});
        step();
        chk({name, "_mreq"}, 32'(bus.m_req), 32'd1);
        chk({name, "_maddr"}, bus.m_addr, addr);
        chk({name, "_mwe"}, 32'(bus.m_we), 32'(port & we));
        chk({name, "_mwdata"}, bus.m_wdata, port ? wdata : 32'd0);
        n = 1; mreq_n = 0; seen = 1'b0;
        while (n <= 300 && !seen) begin
            if (bus.i_ready || bus.d_ready) begin
                seen = 1'b1;
            end else begin
                if (bus.m_req) mreq_n++;
                step();
                n++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_ready: got no ready within 300 cycles required one", name);
        end else begin
            chk({name, "_lat"}, 32'(n), 32'(exp_cyc));
            chk({name, "_mreq_cycles"}, 32'(mreq_n), 32'(exp_cyc - 1));
            pop_cmp(name);
            chk({name, "_oth_rdata"}, port ? bus.i_rdata : bus.d_rdata, oth_rdata);
            chk({name, "_oth_err"}, 32'(port ? bus.i_err : bus.d_err), 32'(oth_err));
            chk({name, "_mreq_off"}, 32'(bus.m_req), 32'd0);
            $display("txn %s port=%s we=%0d addr=%h rdata=%h err=%0d cycles=%0d",
                     name, port ? "D" : "I", we, addr,
                     port ? bus.d_rdata : bus.i_rdata,
                     port ? bus.d_err : bus.i_err, n);
            if (inject_late) late_ack = 1'b1;
            step();
            late_ack = 1'b0;
            chk({name, "_pulse"}, 32'({bus.i_ready, bus.d_ready}), 32'd0);
        end
        if (!keep) begin
            if (port) bus.d_req = 1'b0;
            else      bus.i_req = 1'b0;
        end
    endtask

    initial begin
        bit          ord[10];
        logic [31:0] ia, da, ea_i, ea_d;
        int          done, n;
        bit          pend, pend_port, bad;

        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        1, 32'h0050_0093, 32'h0050_0093, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3, 32'h0,         32'h0,         1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0,        2, 32'h1122_3344, 32'h1122_3344, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h48,  32'h0,        4, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h300, 32'h0,        5, 32'h55AA_55AA, 32'h55AA_55AA, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h304, 32'h0,        0, 32'h7777_7777, 32'h0,         1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h4C,  32'h0,        0, 32'h6666_6666, 32'h0,         1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h50,  32'h0,        1, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0};

        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = 32'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        step();
        step();
        chk("rst_ctrl", 32'({bus.m_req, bus.m_we, bus.i_ready, bus.d_ready, bus.i_err, bus.d_err}), 32'd0);
        chk("rst_maddr", bus.m_addr, 32'd0);
        chk("rst_irdata", bus.i_rdata, 32'd0);
        chk("rst_drdata", bus.d_rdata, 32'd0);
        reset = 1'b0;

        // Table of single accesses
        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].we) mem_img[vecs[i].addr] = vecs[i].mrd;
            do_txn($sformatf("v%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].lat, vecs[i].exp_rdata, vecs[i].exp_err,
                   1'b0, 1'b0);
        end

        // Timeout followed by a stray ack in the ready cycle
        do_txn("late", 1'b1, 1'b0, 32'h308, 32'h0, 0, 32'h0, 1'b1, 1'b0, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.i_ready || bus.d_ready || bus.m_req) bad = 1'b1;
        end
        chk("late_quiet", 32'(bad), 32'd0);
        chk("late_derr_held", 32'(bus.d_err), 32'd1);

        // Reset in the middle of an instruction fetch
        lat_cfg = 0;
        bus.i_req = 1'b1; bus.i_addr = 32'h60;
        step();
        chk("rbusy_mreq", 32'(bus.m_req), 32'd1);
        step();
        reset = 1'b1;
        step();
        chk("rbusy_ctrl", 32'({bus.m_req, bus.m_we, bus.i_ready, bus.d_ready, bus.i_err, bus.d_err}), 32'd0);
        chk("rbusy_maddr", bus.m_addr, 32'd0);
        chk("rbusy_mwdata", bus.m_wdata, 32'd0);
        chk("rbusy_irdata", bus.i_rdata, 32'd0);
        chk("rbusy_drdata", bus.d_rdata, 32'd0);
        reset = 1'b0;
        bus.i_req = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < TIMEOUT + 3; i++) begin
            step();
            if (bus.i_ready || bus.d_ready) bad = 1'b1;
        end
        chk("rbusy_noready", 32'(bad), 32'd0);
        mem_img[32'h64] = 32'h0F0F_1234;
        do_txn("post_rst", 1'b0, 1'b0, 32'h64, 32'h0, 2, 32'h0F0F_1234, 1'b0, 1'b0, 1'b0);

        // Request held through DONE becomes a new transaction
        mem_img[32'h70] = 32'hA1A1_A1A1;
        mem_img[32'h44] = 32'hB2B2_B2B2;
        do_txn("held1", 1'b0, 1'b0, 32'h70, 32'h0, 1, 32'hA1A1_A1A1, 1'b0, 1'b1, 1'b0);
        do_txn("held2", 1'b0, 1'b0, 32'h44, 32'h0, 1, 32'hB2B2_B2B2, 1'b0, 1'b0, 1'b0);

        // Both ports requesting continuously: streak limit forces fetches in
        ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        lat_cfg = 1;
        ia = 32'h1000; da = 32'h2000;
        ea_i = ia; ea_d = da;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back('{ord[k], rdata_of(ord[k] ? ea_d : ea_i), 1'b0});
            if (ord[k]) ea_d += 32'd4;
            else        ea_i += 32'd4;
        end
        bus.d_we = 1'b0;
        bus.i_addr = ia; bus.d_addr = da;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        done = 0; n = 0; pend = 1'b0; pend_port = 1'b0;
        while (done < 10 && n < 200) begin
            step();
            n++;
            if (pend) begin
                pend = 1'b0;
                if (pend_port) begin da += 32'd4; bus.d_addr = da; end
                else           begin ia += 32'd4; bus.i_addr = ia; end
            end
            if (bus.i_ready || bus.d_ready) begin
                $display("txn arb%0d port=%s rdata=%h", done, bus.d_ready ? "D" : "I",
                         bus.d_ready ? bus.d_rdata : bus.i_rdata);
                pend_port = bus.d_ready;
                pop_cmp($sformatf("arb%0d", done));
                pend = 1'b1;
                done++;
            end
        end
        chk("arb_count", 32'(done), 32'd10);
        step();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        step();
        step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-ported backing memory between the instruction-fetch port and the data-access port of the multi-cycle CPU. It replaces the separate instruction and data memories with a unified memory that responds after a variable number of cycles. Requests are serialised: data wins by default, but a streak limit prevents instruction-fetch starvation. A timeout guard retires any request the memory never acknowledges.

## Interface
- STREAK_MAX, 4: maximum consecutive data grants while an instruction request waits; legal range 1..15
- TIMEOUT, 255: maximum cycles in BUSY without m_ack before the request is retired with an error; legal range 1..255
- clk  input  1  sole clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- i_req  input  1  instruction read request; held high until the edge where i_ready=1
- i_addr  input  32  instruction byte address; stable while i_req=1
- i_ready  output  1  one-cycle completion pulse for the instruction port
- i_rdata  output  32  fetched instruction; valid when i_ready=1, held until the next instruction completion
- i_err  output  1  qualifies i_ready: 1 = timeout, i_rdata=0
- d_req  input  1  data request; held high until the edge where d_ready=1
- d_we  input  1  1 = write, 0 = read; stable while d_req=1
- d_addr  input  32  data byte address; stable while d_req=1
- d_wdata  input  32  write data; stable while d_req=1
- d_ready  output  1  one-cycle completion pulse for the data port
- d_rdata  output  32  read data on completion; 0 after a write or a timeout; held until the next data completion
- d_err  output  1  qualifies d_ready: 1 = timeout
- m_req  output  1  request to the backing memory; held high until m_ack
- m_we  output  1  write enable to the backing memory
- m_addr  output  32  byte address to the backing memory
- m_wdata  output  32  write data to the backing memory
- m_ack  input  1  one-cycle completion from the backing memory; may be asserted in any cycle where m_req=1, including the first
- m_rdata  input  32  read data; valid with m_ack

## Operation
- FSM states: IDLE, BUSY, DONE. A granted-port register (INST/DATA) records which port owns the memory.
- IDLE behaviour, evaluated at the edge:
  - No request: stay in IDLE.
  - Only one request: grant that port.
  - Both requests: grant INST if streak == STREAK_MAX; otherwise grant DATA.
  - On a grant: load m_addr, m_we and m_wdata from the granted port, set m_req=1, clear the timeout counter, go to BUSY.
  - For an INST grant, m_we=0 and m_wdata=0.
- Streak counter (4 bits):
  - Increments on a DATA grant while i_req=1.
  - Clears on an INST grant.
  - Clears on a DATA grant while i_req=0.
  - Never exceeds STREAK_MAX.
- BUSY behaviour, evaluated at the edge:
  - m_ack=1: capture the result into the granted port's rdata (m_rdata for a read, 0 for a write), set err=0, drop m_req, go to DONE.
  - m_ack=0 and timeout counter == TIMEOUT-1: set rdata=0, err=1, drop m_req, go to DONE.
  - Otherwise: increment the timeout counter (8 bits).
- DONE: the granted port's ready=1 for exactly this cycle. Next state is IDLE unconditionally.
- A request still high in IDLE after its DONE cycle is a new transaction.
- m_ack received in IDLE or DONE is ignored. This covers a late ack after a timeout and an ack after reset.
- Reset, including mid-transaction:
  - State goes to IDLE; streak and timeout counters go to 0.
  - All outputs go to 0: m_req, m_we, m_addr, m_wdata, i_ready, d_ready, i_rdata, d_rdata, i_err, d_err.
  - A pending transaction is abandoned and no ready pulse is produced.
- The other port's ready, rdata and err are never disturbed by a transaction on the opposite port.

## Timing
- Every output is registered. There are no combinational paths from inputs to outputs.
- Transaction timeline, with request sampled at edge 0 in IDLE and m_ack in the k-th BUSY cycle (k≥1):
  - m_req is high in cycles 1..k.
  - ready is high in cycle k+1.
  - The arbiter is back in IDLE in cycle k+2.
- Minimum turnaround is 3 cycles per access. Back-to-back accesses from one port complete every k+2 cycles.
- Timeout: with no ack, m_req stays high for exactly TIMEOUT cycles, then ready and err go high in the next cycle.
- In the ready cycle the requester keeps req high. The requester must present a new address, or drop req, in the following cycle.

## Test plan
- Reset, then i_req with i_addr=0x40 and memory acking in the first BUSY cycle with m_rdata=0x00500093 → m_req in cycle 1, m_addr=0x40, i_ready in cycle 2 with i_rdata=0x00500093 and i_err=0, state IDLE in cycle 3.
- d_req write with d_addr=0x100, d_wdata=0xDEADBEEF, ack after 3 cycles → m_we=1, m_wdata=0xDEADBEEF, d_ready in cycle 4 with d_rdata=0 and d_err=0; i_rdata unchanged.
- i_req and d_req held continuously with STREAK_MAX=4 and 1-cycle acks → grant order D,D,D,D,I,D,D,D,D,I; streak counter returns to 0 after each INST grant.
- TIMEOUT=5, d_req read, m_ack never asserted → m_req high for exactly 5 cycles, then d_ready=1, d_err=1, d_rdata=0; a late m_ack in the next cycle is ignored with no extra ready pulse.
- reset asserted during BUSY of an instruction fetch → the next cycle has all outputs 0, no i_ready ever appears for that fetch, and a new i_req afterwards completes normally.
- i_req held across its DONE cycle with a new i_addr=0x44 → a second grant in the IDLE cycle, m_addr=0x44 in the following cycle.
